seq_pattern_detector: RTL and testbench

- Parametrised serial bit-pattern recogniser, the successor to the fixed "three consecutive 1s" recogniser.
- Detects an arbitrary PAT_W-bit pattern on a 1-bit serial input.
- Selectable Mealy or Moore output timing, overlapping or non-overlapping detection, and a saturating match counter.
- Sits after a serial receiver front-end; d_out feeds event logic, match_cnt is read by control.

---
 rtl/seq_det_pkg.sv | 28 ++
 rtl/seq_pattern_detector_sat_counter.sv | 41 ++++
 rtl/seq_pattern_detector.sv | 124 ++++++++++++
 tb/tb_seq_pattern_detector.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and elaboration helpers for the serial pattern detector.
// Holds the FSM state encoding, parameter legality checks and fill-width sizing.
package seq_det_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam int unsigned PAT_W_MIN = 32'd2;
   localparam int unsigned PAT_W_MAX = 32'd16;

   function automatic bit pat_w_legal(input int unsigned pat_w);
      return (pat_w >= PAT_W_MIN) && (pat_w <= PAT_W_MAX);
   endfunction

   // PATTERN is carried at full width; any bit above PAT_W-1 must be zero.
   function automatic bit pattern_fits(input logic [PAT_W_MAX-1:0] pattern,
                                       input int unsigned pat_w);
      return (pat_w >= PAT_W_MAX) || ((pattern >> pat_w) == 16'h0000);
   endfunction

   // fill counts up to pat_w-1, so $clog2(pat_w) bits are enough.
   function automatic int unsigned fill_w(input int unsigned pat_w);
      return (pat_w > 32'd2) ? $clog2(pat_w) : 32'd1;
   endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with a synchronous clear that still honours a
// coincident increment; reusable wherever a sticky event count is needed.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Next count: clear wins, but an increment in the same cycle counts as one.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clr) begin
         cnt_nxt_s = inc ? CNT_W'(1) : '0;
      end else if (inc && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign q = cnt_r;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial recogniser for an arbitrary PAT_W-bit pattern (MSB received first),
// with Mealy/Moore output timing, optional overlap and a saturating match count.
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned          PAT_W   = 3,
   parameter logic [PAT_W_MAX-1:0] PATTERN = 16'h0007,
   parameter bit                   MOORE   = 1'b0,
   parameter bit                   OVERLAP = 1'b1,
   parameter int unsigned          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             d_in,
   input  logic             clear_cnt,
   output logic             d_out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);

   localparam int unsigned       FILL_W   = fill_w(PAT_W);
   localparam int unsigned       HIST_W   = PAT_W - 32'd1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 32'd1);
   localparam logic [PAT_W-1:0]  PAT_S    = PATTERN[PAT_W-1:0];

   if (!pat_w_legal(PAT_W) || !pattern_fits(PATTERN, PAT_W)) begin : g_param_chk
      $error("seq_pattern_detector: PAT_W must be 2..16 and PATTERN must fit in PAT_W bits");
   end

   state_t              state_r;
   state_t              state_nxt_s;
   logic [HIST_W-1:0]   hist_r;
   logic [HIST_W-1:0]   hist_nxt_s;
   logic [HIST_W-1:0]   hist_shift_s;
   logic [FILL_W-1:0]   fill_r;
   logic [FILL_W-1:0]   fill_nxt_s;
   logic                match_r;
   logic                hit_s;
   logic                d_unknown_s;

   // Flag an undriven serial input so RUN drops back to IDLE instead of matching garbage.
   always_comb begin
      d_unknown_s = 1'b0;
`ifndef SYNTHESIS
      if (d_in === 1'bx) begin
         d_unknown_s = 1'b1;
      end else begin
         d_unknown_s = 1'b0;
      end
`endif
   end

   assign hist_shift_s = HIST_W'({hist_r, d_in});

   // Next-state, history, fill and hit evaluation.
   always_comb begin
      state_nxt_s = state_r;
      hist_nxt_s  = hist_r;
      fill_nxt_s  = fill_r;
      hit_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (en) begin
               state_nxt_s = S_RUN;
               hist_nxt_s  = hist_shift_s;
               fill_nxt_s  = FILL_W'(1);
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (!en || d_unknown_s) begin
               state_nxt_s = S_IDLE;
               fill_nxt_s  = '0;
            end else begin
               hist_nxt_s = hist_shift_s;
               hit_s      = (fill_r == FILL_MAX) && ({hist_r, d_in} == PAT_S);
               // Without overlap a hit discards history so the next match needs PAT_W new bits.
               if (hit_s && (OVERLAP == 1'b0)) begin
                  fill_nxt_s = '0;
               end else if (fill_r == FILL_MAX) begin
                  fill_nxt_s = fill_r;
               end else begin
                  fill_nxt_s = fill_r + FILL_W'(1);
               end
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            fill_nxt_s  = '0;
         end
      endcase
   end

   // State, history and Moore match registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         hist_r  <= '0;
         fill_r  <= '0;
         match_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         hist_r  <= hist_nxt_s;
         fill_r  <= fill_nxt_s;
         match_r <= hit_s;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hit_s),
      .clr   (clear_cnt),
      .q     (match_cnt)
   );

   assign d_out = MOORE ? match_r : hit_s;
   assign armed = (state_r == S_RUN);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: five parameterisations share one
// stimulus stream, each scenario checks the instance it targets.
module tb_seq_pattern_detector;

   logic clk;
   logic reset;
   logic en;
   logic d_in;
   logic clear_cnt;

   logic       dout_a, dout_b, dout_c, dout_d, dout_e;
   logic       armed_a, armed_b, armed_c, armed_d, armed_e;
   logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
   logic [1:0] cnt_e;

   logic pre_a, pre_b, pre_c, pre_d, pre_e;

   int check_cnt = 0;
   int err_cnt   = 0;

   // A: defaults (111, Mealy, overlap)
   seq_pattern_detector u_a (
      .clk(clk), .reset(reset), .en(en), .d_in(d_in), .clear_cnt(clear_cnt),
      .d_out(dout_a), .match_cnt(cnt_a), .armed(armed_a));

   // B: Moore timing
   seq_pattern_detector #(.MOORE(1'b1)) u_b (
      .clk(clk), .reset(reset), .en(en), .d_in(d_in), .clear_cnt(clear_cnt),
      .d_out(dout_b), .match_cnt(cnt_b), .armed(armed_b));

   // C: non-overlapping
   seq_pattern_detector #(.OVERLAP(1'b0)) u_c (
      .clk(clk), .reset(reset), .en(en), .d_in(d_in), .clear_cnt(clear_cnt),
      .d_out(dout_c), .match_cnt(cnt_c), .armed(armed_c));

   // D: 4-bit pattern 1011
   seq_pattern_detector #(.PAT_W(4), .PATTERN(16'h000B)) u_d (
      .clk(clk), .reset(reset), .en(en), .d_in(d_in), .clear_cnt(clear_cnt),
      .d_out(dout_d), .match_cnt(cnt_d), .armed(armed_d));

   // E: 2-bit counter
   seq_pattern_detector #(.CNT_W(2)) u_e (
      .clk(clk), .reset(reset), .en(en), .d_in(d_in), .clear_cnt(clear_cnt),
      .d_out(dout_e), .match_cnt(cnt_e), .armed(armed_e));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle: inputs at negedge, capture Mealy outputs before the edge,
   // return #1 after the rising edge so registered outputs are settled.
   task automatic cyc(input logic r, input logic e, input logic d, input logic c);
      @(negedge clk);
      reset = r; en = e; d_in = d; clear_cnt = c;
      #1;
      pre_a = dout_a; pre_b = dout_b; pre_c = dout_c; pre_d = dout_d; pre_e = dout_e;
      @(posedge clk);
      #1;
   endtask

   logic s1_bits [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic s1_hits [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic s3_hits [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic s4_bits [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic s4_hits [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic s5_hits [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic s5_en   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [1:0] s6_cnt [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      reset = 1'b1; en = 1'b0; d_in = 1'b0; clear_cnt = 1'b0;

      // Reset state
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("rst_dout_a", dout_a, 1'b0);
      check_eq("rst_dout_b", dout_b, 1'b0);
      check_eq("rst_armed_a", armed_a, 1'b0);
      check_eq("rst_cnt_a", cnt_a, 8'd0);

      // Scenarios 1 and 2: Mealy hit before the edge, Moore pulse after it
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, s1_bits[i], 1'b0);
         check_eq($sformatf("s1_mealy_%0d", i), pre_a, s1_hits[i]);
         check_eq($sformatf("s2_moore_%0d", i), dout_b, s1_hits[i]);
         check_eq($sformatf("s1_armed_%0d", i), armed_a, 1'b1);
      end
      check_eq("s1_cnt", cnt_a, 8'd2);
      check_eq("s2_cnt", cnt_b, 8'd2);

      // Scenario 3: non-overlapping 111 on six 1s
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0);
         check_eq($sformatf("s3_hit_%0d", i), pre_c, s3_hits[i]);
      end
      check_eq("s3_cnt", cnt_c, 8'd2);

      // Scenario 4: 1011 with overlap through the shared 1
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, 1'b1, s4_bits[i], 1'b0);
         check_eq($sformatf("s4_hit_%0d", i), pre_d, s4_hits[i]);
      end
      check_eq("s4_cnt", cnt_d, 8'd2);

      // Scenario 5: abort after two 1s, then three fresh 1s needed
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, s5_en[i], 1'b1, 1'b0);
         check_eq($sformatf("s5_hit_%0d", i), pre_a, s5_hits[i]);
         check_eq($sformatf("s5_armed_%0d", i), armed_a, s5_en[i]);
      end
      check_eq("s5_cnt1", cnt_a, 8'd1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("s5_cnt2", cnt_a, 8'd2);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      check_eq("s5_rst_cnt", cnt_a, 8'd0);
      check_eq("s5_rst_armed", armed_a, 1'b0);
      check_eq("s5_rst_dout", dout_a, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0);
         check_eq($sformatf("s5_post_%0d", i), pre_a, (i == 2) ? 1'b1 : 1'b0);
      end
      check_eq("s5_post_cnt", cnt_a, 8'd1);

      // Scenario 6: 2-bit counter saturation and clear priority
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0);
         check_eq($sformatf("s6_cnt_%0d", i), cnt_e, s6_cnt[i]);
      end
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("s6_clr_hit_pre", pre_e, 1'b1);
      check_eq("s6_clr_hit", cnt_e, 2'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("s6_clr_only", cnt_e, 2'd0);

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
